// File: rtl/l1_refill_ctrl_if.sv
// ============================================================================
// l1_refill_ctrl_if : L1 request channel plus single-beat system bus signals
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface l1_refill_ctrl_if;
  logic        write_through_req;
  logic        read_req;
  logic        read_line_req;
  logic [3:0]  L1_size;
  logic [63:0] pa;
  logic [63:0] wt_data;
  logic [63:0] line_data;
  logic [10:0] addr_count;
  logic        line_write;
  logic        cache_entry_write;
  logic        trans_rdy;
  logic        bus_error;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [3:0]  bus_size;
  logic [63:0] bus_wdata;
  logic [63:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  // master: the refill controller's view; slave: the L1 plus bus responder
  modport master (
    input  write_through_req, read_req, read_line_req, L1_size, pa, wt_data,
           bus_rdata, bus_ack, bus_err,
    output line_data, addr_count, line_write, cache_entry_write, trans_rdy,
           bus_error, bus_req, bus_we, bus_addr, bus_size, bus_wdata
  );

  modport slave (
    output write_through_req, read_req, read_line_req, L1_size, pa, wt_data,
           bus_rdata, bus_ack, bus_err,
    input  line_data, addr_count, line_write, cache_entry_write, trans_rdy,
           bus_error, bus_req, bus_we, bus_addr, bus_size, bus_wdata
  );
endinterface

`default_nettype wire

// File: rtl/l1_refill_ctrl.sv
// ============================================================================
// l1_refill_ctrl : L1 refill / write-through responder driving single-beat bus
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module l1_refill_ctrl #(
  parameter int LINE_BEATS = 256,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  l1_refill_ctrl_if.master  io
);

  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SGL_RD  = 3'd1;
  localparam logic [2:0] S_SGL_WR  = 3'd2;
  localparam logic [2:0] S_LINE_RD = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_FAIL    = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [63:0]       r_pa;
  logic [3:0]        r_size;
  logic [63:0]       r_wdata;
  logic              r_is_line;
  logic [BEAT_W-1:0] r_beat;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_drain;
  logic              r_hold;
  logic [63:0]       r_line_data;
  logic [10:0]       r_addr_count;
  logic              r_line_write;

  logic              w_busy;
  logic              w_ack;
  logic              w_timeout;
  logic              w_last_beat;
  logic [10:0]       w_line_off;

  // r_drain: last fill beat acked, waiting one cycle so its line_write precedes DONE
  assign w_busy      = (r_state == S_SGL_RD) || (r_state == S_SGL_WR) ||
                       ((r_state == S_LINE_RD) && !r_drain);
  assign w_ack       = w_busy && io.bus_ack && !io.bus_err;
  assign w_last_beat = (r_beat == BEAT_W'(LINE_BEATS - 1));
  assign w_line_off  = 11'(r_beat) << 3;

  generate
    if (TIMEOUT > 0) begin : g_tmo_on
      assign w_timeout = w_busy && (r_tmo == TMO_W'(TIMEOUT - 1));
    end else begin : g_tmo_off
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_hold) begin
          if      (io.write_through_req) w_next = S_SGL_WR;
          else if (io.read_line_req)     w_next = S_LINE_RD;
          else if (io.read_req)          w_next = S_SGL_RD;
        end
      end
      S_SGL_RD, S_SGL_WR: begin
        if      (io.bus_err) w_next = S_FAIL;
        else if (io.bus_ack) w_next = S_DONE;
        else if (w_timeout)  w_next = S_FAIL;
      end
      S_LINE_RD: begin
        if      (r_drain)    w_next = S_DONE;
        else if (io.bus_err) w_next = S_FAIL;
        else if (io.bus_ack) w_next = S_LINE_RD;
        else if (w_timeout)  w_next = S_FAIL;
      end
      S_DONE, S_FAIL: w_next = S_IDLE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pa         <= '0;
      r_size       <= '0;
      r_wdata      <= '0;
      r_is_line    <= 1'b0;
      r_beat       <= '0;
      r_tmo        <= '0;
      r_drain      <= 1'b0;
      r_hold       <= 1'b0;
      r_line_data  <= '0;
      r_addr_count <= '0;
      r_line_write <= 1'b0;
    end else begin
      r_line_write <= 1'b0;
      r_hold       <= (r_state == S_DONE) || (r_state == S_FAIL);
      if ((r_state == S_IDLE) && (w_next != S_IDLE)) begin
        r_pa      <= io.pa;
        r_size    <= io.L1_size;
        r_wdata   <= io.wt_data;
        r_is_line <= (w_next == S_LINE_RD);
        r_beat    <= '0;
        r_drain   <= 1'b0;
      end
      if ((w_next != r_state) || w_ack) r_tmo <= '0;
      else if (w_busy)                  r_tmo <= r_tmo + TMO_W'(1);
      if (w_ack && (r_state == S_SGL_RD)) r_line_data <= io.bus_rdata;
      if (w_ack && (r_state == S_LINE_RD)) begin
        r_line_data  <= io.bus_rdata;
        r_addr_count <= w_line_off;
        r_line_write <= 1'b1;
        if (w_last_beat) r_drain <= 1'b1;
        else             r_beat  <= r_beat + BEAT_W'(1);
      end
    end
  end

  always_comb begin
    io.bus_req   = w_busy;
    io.bus_we    = 1'b0;
    io.bus_addr  = '0;
    io.bus_size  = '0;
    io.bus_wdata = '0;
    if (w_busy) begin
      if (r_state == S_LINE_RD) begin
        io.bus_addr = {r_pa[63:11], w_line_off};
        io.bus_size = 4'b1000;
      end else begin
        io.bus_addr = r_pa;
        io.bus_size = r_size;
      end
      if (r_state == S_SGL_WR) begin
        io.bus_we    = 1'b1;
        io.bus_wdata = r_wdata;
      end
    end
    io.trans_rdy         = (r_state == S_DONE);
    io.bus_error         = (r_state == S_FAIL);
    io.cache_entry_write = (r_state == S_DONE) && r_is_line;
    io.line_data         = r_line_data;
    io.addr_count        = r_addr_count;
    io.line_write        = r_line_write;
  end

endmodule

`default_nettype wire

// File: tb/tb_l1_refill_ctrl.sv
// ============================================================================
// tb_l1_refill_ctrl : acts as L1 and bus responder, checks against a beat model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_l1_refill_ctrl;
  localparam int LINE_BEATS = 256;
  localparam int TIMEOUT    = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [63:0] model_ld = '0;
  logic [10:0] model_ac = '0;

  always #5 clk = ~clk;

  l1_refill_ctrl_if bus_if ();

  l1_refill_ctrl #(.LINE_BEATS(LINE_BEATS), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus_if.master)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, 64'({bus_if.bus_req, bus_if.trans_rdy, bus_if.bus_error,
                  bus_if.line_write, bus_if.cache_entry_write}), 64'd0);
  endtask

  task automatic clear_reqs();
    bus_if.write_through_req = 1'b0;
    bus_if.read_line_req     = 1'b0;
    bus_if.read_req          = 1'b0;
  endtask

  // reqs = {write_through, read_line, read}; err_beat < 0 means no bus_err
  task automatic run_txn(input logic [2:0] reqs, input logic [63:0] pa, input logic [3:0] size,
                         input logic [63:0] wd, input logic [63:0] d0, input int stall_lo,
                         input int stall_hi, input int err_beat, input bit never_ack,
                         input bit drop_early, input int rst_beat);
    logic [63:0] data [LINE_BEATS];
    logic [63:0] exp_a;
    int  kind;
    int  beat = 0, stall = 0, lw = 0, tr = 0, be = 0, cew = 0, req_hi = 0, cyc = 0, acked = 0;
    bit  done = 0, aborted = 0, newbeat = 1, complete = 0;
    kind = reqs[2] ? 1 : (reqs[1] ? 2 : 0);
    for (int k = 0; k < LINE_BEATS; k++) data[k] = {$urandom, $urandom};
    data[0] = d0;
    @(negedge clk);
    bus_if.pa                = pa;
    bus_if.L1_size           = size;
    bus_if.wt_data           = wd;
    bus_if.write_through_req = reqs[2];
    bus_if.read_line_req     = reqs[1];
    bus_if.read_req          = reqs[0];
    stall = $urandom_range(stall_hi, stall_lo);
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_err   = 1'b0;
      bus_if.bus_rdata = {$urandom, $urandom};
      if (bus_if.line_write) begin
        chk("lw_data", bus_if.line_data, data[lw]);
        chk("lw_addr_count", 64'(bus_if.addr_count), 64'(lw * 8));
        chk("lw_not_with_done", 64'(bus_if.trans_rdy), 64'd0);
        lw++;
      end
      if (bus_if.bus_req) begin
        if (rst_beat >= 0 && beat == rst_beat) begin
          #1 rst = 1'b0;
          #1;
          chk_quiet("rst_async_outputs");
          chk("rst_line_data", bus_if.line_data, 64'd0);
          chk("rst_addr_count", 64'(bus_if.addr_count), 64'd0);
          chk("rst_bus_addr", bus_if.bus_addr, 64'd0);
          aborted = 1;
          done    = 1;
        end else begin
          req_hi++;
          if (newbeat) begin
            exp_a = (kind == 2) ? ((pa & ~64'h7FF) + 64'(beat) * 64'd8) : pa;
            chk("bus_addr", bus_if.bus_addr, exp_a);
            chk("bus_size", 64'(bus_if.bus_size), (kind == 2) ? 64'd8 : 64'(size));
            chk("bus_we", 64'(bus_if.bus_we), (kind == 1) ? 64'd1 : 64'd0);
            if (kind == 1) chk("bus_wdata", bus_if.bus_wdata, wd);
            newbeat = 0;
          end
          if (!never_ack) begin
            if (stall > 0) stall--;
            else if (beat == err_beat) begin
              bus_if.bus_err = 1'b1;
              bus_if.bus_ack = 1'($urandom_range(1, 0));
            end else begin
              bus_if.bus_ack   = 1'b1;
              bus_if.bus_rdata = data[beat];
              beat++;
              newbeat = 1;
              stall   = $urandom_range(stall_hi, stall_lo);
            end
          end
        end
      end
      if (drop_early && req_hi > 0) clear_reqs();
      if (bus_if.trans_rdy) tr++;
      if (bus_if.bus_error) begin
        be++;
        if (never_ack) begin
          chk("timeout_cycles", 64'(req_hi), 64'(TIMEOUT));
          chk("timeout_bus_req_low", 64'(bus_if.bus_req), 64'd0);
        end
      end
      if (bus_if.cache_entry_write) cew++;
      if (bus_if.trans_rdy || bus_if.bus_error) done = 1;
    end
    chk("txn_finished", 64'(done), 64'd1);
    if (aborted) begin
      clear_reqs();
      bus_if.bus_ack = 1'b0;
      bus_if.bus_err = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk_quiet("rst_held_quiet");
      end
      rst      = 1'b1;
      model_ld = '0;
      model_ac = '0;
      @(negedge clk);
      chk_quiet("rst_release_quiet");
    end else begin
      complete = (err_beat < 0) && !never_ack;
      if (kind != 2)      acked = complete ? 1 : 0;
      else if (never_ack) acked = 0;
      else                acked = (err_beat >= 0) ? err_beat : LINE_BEATS;
      chk("trans_rdy_count", 64'(tr), complete ? 64'd1 : 64'd0);
      chk("bus_error_count", 64'(be), complete ? 64'd0 : 64'd1);
      chk("cache_entry_write_count", 64'(cew), (complete && kind == 2) ? 64'd1 : 64'd0);
      chk("line_write_count", 64'(lw), (kind == 2) ? 64'(acked) : 64'd0);
      if (kind == 0 && complete) model_ld = data[0];
      if (kind == 2 && acked > 0) begin
        model_ld = data[acked - 1];
        model_ac = 11'((acked - 1) * 8);
      end
      chk("end_line_data", bus_if.line_data, model_ld);
      chk("end_addr_count", 64'(bus_if.addr_count), 64'(model_ac));
      // request stays high one cycle into IDLE; it must not be re-accepted
      @(negedge clk);
      chk_quiet("idle_gap_1");
      @(negedge clk);
      chk_quiet("idle_gap_2");
      clear_reqs();
      @(negedge clk);
      chk_quiet("idle_gap_3");
    end
    bus_if.bus_ack = 1'b0;
    bus_if.bus_err = 1'b0;
  endtask

  logic [2:0] r_mask;
  int         r_eb;

  initial begin
    clear_reqs();
    bus_if.pa        = '0;
    bus_if.L1_size   = '0;
    bus_if.wt_data   = '0;
    bus_if.bus_rdata = '0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_err   = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset_strobes");
    chk("reset_line_data", bus_if.line_data, 64'd0);
    chk("reset_addr_count", 64'(bus_if.addr_count), 64'd0);
    chk("reset_bus_addr", bus_if.bus_addr, 64'd0);
    chk("reset_bus_fields", 64'({bus_if.bus_we, bus_if.bus_size}), 64'd0);
    chk("reset_bus_wdata", bus_if.bus_wdata, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_txn(3'b001, 64'h8000_0010, 4'b0100, 64'd0, 64'hDEAD, 3, 3, -1, 0, 0, -1);
    run_txn(3'b100, 64'h100, 4'b1000, 64'h55AA, 64'd0, 0, 2, -1, 0, 0, -1);
    run_txn(3'b010, 64'h1234_5F08, 4'b1000, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 3, -1, 0, 0, -1);
    run_txn(3'b010, 64'h4000_0000, 4'b1000, 64'd0, 64'h11, 0, 2, 5, 0, 0, -1);
    run_txn(3'b001, 64'h2000_0008, 4'b1000, 64'd0, 64'h22, 0, 0, -1, 1, 0, -1);
    run_txn(3'b010, 64'h7777_07F8, 4'b1000, 64'd0, 64'h33, 0, 0, -1, 0, 1, -1);
    run_txn(3'b111, 64'h3000, 4'b0010, 64'hCAFE, 64'h44, 0, 1, -1, 0, 0, -1);
    run_txn(3'b011, 64'h9000_0000, 4'b0001, 64'd0, 64'h55, 0, 1, -1, 0, 0, -1);
    run_txn(3'b100, 64'h5000, 4'b0100, 64'hBEEF, 64'd0, 1, 2, 0, 0, 0, -1);
    run_txn(3'b010, 64'hABC0_0000, 4'b1000, 64'd0, 64'h66, 0, 1, -1, 0, 0, 100);
    run_txn(3'b001, 64'h8000_0020, 4'b0100, 64'd0, 64'h0BAD_F00D, 0, 2, -1, 0, 0, -1);

    for (int t = 0; t < 8; t++) begin
      r_mask = 3'($urandom_range(7, 1));
      r_eb   = -1;
      if ($urandom_range(3, 0) == 0)
        r_eb = (r_mask[2] || !r_mask[1]) ? 0 : int'($urandom_range(LINE_BEATS - 1, 0));
      run_txn(r_mask, {$urandom, $urandom}, 4'(1 << $urandom_range(3, 0)), {$urandom, $urandom},
              {$urandom, $urandom}, 0, int'($urandom_range(4, 0)), r_eb, 0, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
